uart_transmitter: RTL and testbench
===================================

Name: uart_transmitter

Overview:
- UART transmit stage that sits directly upstream of the team's UART receiver and drives its serial input.
- Serializes one byte per frame: start(0), D0..D7 LSB first, even parity (XOR of D7..D0), stop(1).
- Bit timing uses the same baud_select encoding and 16 sample-ticks-per-bit scheme as the receiver, so TxD can connect straight to Rx_D in loopback.

Parameters:
- CLK_FREQ, 50_000_000, system clock frequency in Hz; used to derive tick divisors.
- TICKS_PER_BIT, 16, sample ticks per serial bit; must equal the receiver's oversampling.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-low reset; all state is cleared on the clk edge while reset==0.
- baud_select  input  3  rate: 000=300, 001=1200, 010=4800, 011=9600, 100=19200, 101=38400, 110=57600, 111=115200.
- Tx_EN  input  1  transmitter enable.
- Tx_WR  input  1  one-cycle write strobe for Tx_DATA.
- Tx_DATA  input  8  byte to send.
- TxD  output  1  serial line; idles high.
- Tx_BUSY  output  1  high from the cycle after acceptance until the stop bit ends.
- Tx_DONE  output  1  one-cycle pulse on the last cycle of the stop bit.

Behaviour:
- Reset values: TxD=1, Tx_BUSY=0, Tx_DONE=0, state=IDLE, tick and bit counters=0, divider=0.
- Tick generator:
  - Divisor = round(CLK_FREQ/(16*baud)). At 50 MHz: 10417, 2604, 651, 326, 163, 81, 54, 27.
  - Emits a 1-cycle tick when the divider reaches divisor-1, then wraps to 0.
  - Divider is cleared on frame acceptance, so the start bit is full width.
- Acceptance:
  - In IDLE with Tx_EN=1 and Tx_WR=1, Tx_DATA is latched into a shift register and the parity bit is computed.
  - Next cycle: state=START, TxD=0, Tx_BUSY=1.
  - baud_select is latched at acceptance; changing it mid-frame has no effect until the next frame.
- FSM states and transitions:
  - IDLE -> START: on acceptance.
  - START -> DATA: after 16 ticks.
  - DATA: shifts one bit every 16 ticks; an index of 0..7 selects D0..D7. DATA -> PARITY after index 7.
  - PARITY -> STOP: after 16 ticks.
  - STOP -> IDLE: after 16 ticks. Tx_DONE=1 on the final cycle of STOP; Tx_BUSY drops the following cycle.
  - Unused encodings go to IDLE with TxD=1.
- Frame length: exactly 11*16*divisor clocks from the first TxD=0 cycle to the return to IDLE.
- TxD is registered (glitch-free) and is 1 in every state other than START, DATA and PARITY.
- Tx_WR while Tx_BUSY=1 is ignored unless UART_TX_BUF_EN is defined.
- Tx_WR with Tx_EN=0 is ignored.
- Tx_EN deasserted mid-frame:
  - Frame aborts next cycle: TxD=1, Tx_BUSY=0, no Tx_DONE, state=IDLE.
  - The receiver then sees the truncated frame as a framing error.
- Reset asserted mid-frame: same effect as the reset values on the next clk edge.
- Tx_WR on the same cycle as Tx_DONE: accepted only with the buffer option; otherwise ignored, because the FSM is not yet in IDLE.

Optional Feature:
- Macro: UART_TX_BUF_EN.
- Defined:
  - Adds a one-entry holding register plus a valid flag.
  - Tx_WR while busy (and Tx_EN=1) loads the holding register.
  - On leaving STOP with the holding register valid, the FSM goes straight to START with that byte: back-to-back frames with no idle gap.
  - A second write while the holding register is full is dropped.
  - Tx_BUSY stays high while the holding register is valid.
  - Reset and Tx_EN=0 clear the valid flag.
- Not defined: no holding register, and writes while busy are ignored.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants: IDLE, START, DATA, PARITY, STOP;
  - the baud_select-to-divisor function/table;
  - TICKS_PER_BIT;
  - the parity definition (even: XOR of data bits).
  The receiver adopts the same package.
- Sub-module: uart_tx_tick_gen. Inputs: clk, reset, baud_select, clear. Output: tick.

Test Plan:
- Reset low 3 cycles, then high: TxD=1, Tx_BUSY=0, Tx_DONE=0. With no Tx_WR, TxD stays 1 for 10000 cycles.
- baud_select=111, Tx_WR with Tx_DATA=0x55:
  - TxD sequence 0,1,0,1,0,1,0,1,0,0(parity),1, each bit held 432 clocks.
  - Tx_DONE pulses once, 4752 clocks after the start edge.
- Tx_DATA=0x01 at baud_select=111: parity bit=1. Loopback into the receiver gives Rx_VALID=1, Rx_DATA=0x01, Rx_PERROR=0, Rx_FERROR=0.
- Tx_WR with 0xA3 during the DATA bits of a 0x0F frame:
  - Without the macro: only 0x0F is sent.
  - With UART_TX_BUF_EN: 0xA3's start bit begins the cycle after 0x0F's stop bit, with no idle gap.
- Tx_EN driven low at bit 4 of a frame: TxD=1 and Tx_BUSY=0 the next cycle, and no Tx_DONE pulse.
- reset driven low mid-PARITY: outputs return to their reset values at the next edge. A fresh Tx_WR of 0xFF afterwards gives a correct frame with parity 0.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_pkg                                               |
// | Brief   : Shared UART types, state encoding, divisor and parity. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package uart_pkg;

  localparam int unsigned TICKS_PER_BIT = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  // Even parity: the parity bit makes the total count of ones even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  // round(clk_freq / (ticks * baud)) for each baud_select code.
  function automatic logic [15:0] baud_divisor(input int unsigned clk_freq,
                                               input int unsigned ticks,
                                               input logic [2:0]  sel);
    int unsigned baud;
    int unsigned denom;
    int unsigned div;
    case (sel)
      3'b000:  baud = 300;
      3'b001:  baud = 1200;
      3'b010:  baud = 4800;
      3'b011:  baud = 9600;
      3'b100:  baud = 19200;
      3'b101:  baud = 38400;
      3'b110:  baud = 57600;
      default: baud = 115200;
    endcase
    denom = ticks * baud;
    div   = (clk_freq + denom / 2) / denom;
    return div[15:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_tick_gen.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_tx_tick_gen                                       |
// | Brief   : Sample-tick divider, one-cycle tick every divisor clks.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_tx_tick_gen #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned TICKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       clear,
  output logic       tick
);
  import uart_pkg::*;

  logic [15:0] w_divisor;
  logic [15:0] w_div_last;
  logic [15:0] r_div;

  assign w_divisor  = baud_divisor(CLK_FREQ, TICKS_PER_BIT, baud_select);
  assign w_div_last = w_divisor - 16'd1;
  // >= keeps the divider from running away if the divisor ever shrinks
  assign tick       = (r_div >= w_div_last);

  always_ff @(posedge clk) begin
    if (!reset || clear || tick) begin
      r_div <= '0;
    end else begin
      r_div <= r_div + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : uart_transmitter                                       |
// | Brief   : 8E1 UART serializer; UART_TX_BUF_EN adds a holding reg.|
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module uart_transmitter #(
  parameter int unsigned CLK_FREQ      = 50_000_000,
  parameter int unsigned TICKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       Tx_EN,
  input  logic       Tx_WR,
  input  logic [7:0] Tx_DATA,
  output logic       TxD,
  output logic       Tx_BUSY,
  output logic       Tx_DONE
);
  import uart_pkg::*;

  localparam int unsigned c_tick_w = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
  localparam logic [c_tick_w-1:0] c_last_tick = c_tick_w'(TICKS_PER_BIT - 1);
  localparam logic [c_tick_w-1:0] c_tick_one  = c_tick_w'(1);

  tx_state_t           r_state, w_state_next;
  logic [c_tick_w-1:0] r_tick_cnt, w_tick_cnt_next;
  logic [2:0]          r_bit_idx, w_bit_next;
  logic [7:0]          r_shift, w_shift_next;
  logic                r_parity, w_parity_next;
  logic [2:0]          r_baud, w_baud_next;
  logic                r_txd, w_txd_next;
  logic                w_tick, w_bit_end, w_clear, w_done;
  logic                w_accept, w_reload;
  logic [7:0]          w_accept_data;
  logic                w_pend_valid, w_hold_busy;
  logic [7:0]          w_pend_data;

  uart_tx_tick_gen #(
    .CLK_FREQ      (CLK_FREQ),
    .TICKS_PER_BIT (TICKS_PER_BIT)
  ) u_tick_gen (
    .clk         (clk),
    .reset       (reset),
    .baud_select (r_baud),
    .clear       (w_clear),
    .tick        (w_tick)
  );

  assign w_bit_end = w_tick && (r_tick_cnt == c_last_tick);

`ifdef UART_TX_BUF_EN
  logic [7:0] r_hold;
  logic       r_hold_valid;

  always_ff @(posedge clk) begin
    if (!reset || !Tx_EN) begin
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
    end else if (w_reload) begin
      r_hold_valid <= 1'b0;
    end else if (Tx_WR && (r_state != IDLE) && !r_hold_valid) begin
      r_hold       <= Tx_DATA;
      r_hold_valid <= 1'b1;
    end
  end

  // A write landing on the final stop cycle chains directly as well
  assign w_pend_valid = r_hold_valid || Tx_WR;
  assign w_pend_data  = r_hold_valid ? r_hold : Tx_DATA;
  assign w_hold_busy  = r_hold_valid;
`else
  assign w_pend_valid = 1'b0;
  assign w_pend_data  = 8'h00;
  assign w_hold_busy  = 1'b0;
`endif

  always_comb begin
    w_state_next    = r_state;
    w_tick_cnt_next = r_tick_cnt;
    w_bit_next      = r_bit_idx;
    w_shift_next    = r_shift;
    w_parity_next   = r_parity;
    w_baud_next     = r_baud;
    w_clear         = 1'b0;
    w_done          = 1'b0;
    w_accept        = 1'b0;
    w_reload        = 1'b0;
    w_accept_data   = Tx_DATA;
    w_txd_next      = 1'b1;

    if (w_tick) begin
      w_tick_cnt_next = r_tick_cnt + c_tick_one;
    end

    case (r_state)
      IDLE: begin
        w_accept = Tx_EN && Tx_WR;
      end
      START: begin
        if (w_bit_end) begin
          w_state_next    = DATA;
          w_bit_next      = 3'd0;
          w_tick_cnt_next = '0;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_tick_cnt_next = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_next = PARITY;
          end else begin
            w_bit_next   = r_bit_idx + 3'd1;
            w_shift_next = {1'b0, r_shift[7:1]};
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_next    = STOP;
          w_tick_cnt_next = '0;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_done          = 1'b1;
          w_tick_cnt_next = '0;
          if (w_pend_valid) begin
            w_accept      = 1'b1;
            w_reload      = 1'b1;
            w_accept_data = w_pend_data;
          end else begin
            w_state_next = IDLE;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    if (w_accept) begin
      w_state_next    = START;
      w_shift_next    = w_accept_data;
      w_parity_next   = even_parity(w_accept_data);
      w_baud_next     = baud_select;
      w_clear         = 1'b1;
      w_tick_cnt_next = '0;
      w_bit_next      = 3'd0;
    end

    // Dropping the enable abandons the frame; the receiver flags it as a framing error
    if (!Tx_EN) begin
      w_state_next = IDLE;
      w_done       = 1'b0;
    end

    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = w_shift_next[0];
      PARITY:  w_txd_next = w_parity_next;
      default: w_txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_tick_cnt <= '0;
      r_bit_idx  <= 3'd0;
      r_shift    <= 8'h00;
      r_parity   <= 1'b0;
      r_baud     <= 3'd0;
      r_txd      <= 1'b1;
    end else begin
      r_state    <= w_state_next;
      r_tick_cnt <= w_tick_cnt_next;
      r_bit_idx  <= w_bit_next;
      r_shift    <= w_shift_next;
      r_parity   <= w_parity_next;
      r_baud     <= w_baud_next;
      r_txd      <= w_txd_next;
    end
  end

  assign TxD     = r_txd;
  assign Tx_BUSY = (r_state != IDLE) || w_hold_busy;
  assign Tx_DONE = w_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module  : tb_uart_transmitter                                    |
// | Brief   : Directed bench for uart_transmitter at 115200 baud.    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_uart_transmitter;

  localparam int BIT_CLKS   = 16 * 27;
  localparam int FRAME_CLKS = 11 * BIT_CLKS;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] baud_select = 3'b111;
  logic       Tx_EN = 1'b1;
  logic       Tx_WR = 1'b0;
  logic [7:0] Tx_DATA = 8'h00;
  logic       TxD, Tx_BUSY, Tx_DONE;

  int n_cmp = 0;
  int n_bad = 0;

  uart_transmitter dut (
    .clk         (clk),
    .reset       (reset),
    .baud_select (baud_select),
    .Tx_EN       (Tx_EN),
    .Tx_WR       (Tx_WR),
    .Tx_DATA     (Tx_DATA),
    .TxD         (TxD),
    .Tx_BUSY     (Tx_BUSY),
    .Tx_DONE     (Tx_DONE)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Frame bit k: 0 start, 1..8 D0..D7, 9 even parity, 10 stop
  function automatic logic frame_bit(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return d[k-1];
    if (k == 9) return ^d;
    return 1'b1;
  endfunction

  task automatic send(input logic [7:0] d);
    @(negedge clk);
    Tx_DATA = d;
    Tx_WR   = 1'b1;
    @(negedge clk);
    Tx_WR   = 1'b0;
  endtask

  // Walks one frame cycle by cycle, starting on the first TxD=0 sample
  task automatic observe_frame(input string tag, input logic [7:0] d,
                               input int inj_at, input logic [7:0] inj_d,
                               output logic par_bit, output logic stop_bit);
    int w = 0;
    int bit_err = 0;
    int busy_err = 0;
    int dones = 0;
    int done_at = 0;
    par_bit  = 1'bx;
    stop_bit = 1'bx;
    while (TxD !== 1'b0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({tag, "/start"}, 32'(TxD), 32'd0);
    for (int c = 1; c <= FRAME_CLKS; c++) begin
      if (TxD !== frame_bit(d, (c - 1) / BIT_CLKS)) bit_err++;
      if (Tx_BUSY !== 1'b1) busy_err++;
      if (Tx_DONE === 1'b1) begin
        dones++;
        done_at = c;
      end
      if (c == 9 * BIT_CLKS + BIT_CLKS / 2) par_bit = TxD;
      if (c == 10 * BIT_CLKS + BIT_CLKS / 2) stop_bit = TxD;
      if (c == inj_at) begin
        Tx_DATA = inj_d;
        Tx_WR   = 1'b1;
      end
      if (c == inj_at + 1) Tx_WR = 1'b0;
      if (c < FRAME_CLKS) @(negedge clk);
    end
    check({tag, "/bit_errors"}, 32'(bit_err), 32'd0);
    check({tag, "/busy_errors"}, 32'(busy_err), 32'd0);
    check({tag, "/done_count"}, 32'(dones), 32'd1);
    check({tag, "/done_cycle"}, 32'(done_at), 32'(FRAME_CLKS));
  endtask

  initial begin
    int   n;
    logic par, stp;

    // Reset state
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("rst/TxD", 32'(TxD), 32'd1);
    check("rst/busy", 32'(Tx_BUSY), 32'd0);
    check("rst/done", 32'(Tx_DONE), 32'd0);
    reset = 1'b1;

    n = 0;
    repeat (10000) begin
      @(negedge clk);
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0 || Tx_DONE !== 1'b0) n++;
    end
    check("idle/quiet", 32'(n), 32'd0);

    // 0x55: alternating data bits, parity 0
    send(8'h55);
    check("x55/accept_txd", 32'(TxD), 32'd0);
    check("x55/accept_busy", 32'(Tx_BUSY), 32'd1);
    observe_frame("x55", 8'h55, -10, 8'h00, par, stp);
    check("x55/parity", 32'(par), 32'd0);
    check("x55/stop", 32'(stp), 32'd1);
    @(negedge clk);
    check("x55/busy_after", 32'(Tx_BUSY), 32'd0);
    check("x55/txd_after", 32'(TxD), 32'd1);

    // 0x01: parity 1; baud_select moved mid-frame must not change timing
    send(8'h01);
    baud_select = 3'b000;
    observe_frame("x01", 8'h01, -10, 8'h00, par, stp);
    check("x01/parity", 32'(par), 32'd1);
    check("x01/stop", 32'(stp), 32'd1);
    baud_select = 3'b111;
    @(negedge clk);
    check("x01/busy_after", 32'(Tx_BUSY), 32'd0);

    // Write with the enable low is ignored
    Tx_EN = 1'b0;
    send(8'h5A);
    n = 0;
    repeat (300) begin
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) n++;
      @(negedge clk);
    end
    check("en_low/ignored", 32'(n), 32'd0);
    Tx_EN = 1'b1;

    // Second write during the data bits of a 0x0F frame
    send(8'h0F);
    observe_frame("x0F", 8'h0F, 3 * BIT_CLKS + 100, 8'hA3, par, stp);
    @(negedge clk);
`ifdef UART_TX_BUF_EN
    check("xA3/no_gap_txd", 32'(TxD), 32'd0);
    check("xA3/no_gap_busy", 32'(Tx_BUSY), 32'd1);
    observe_frame("xA3", 8'hA3, -10, 8'h00, par, stp);
    check("xA3/parity", 32'(par), 32'd0);
    @(negedge clk);
    check("xA3/busy_after", 32'(Tx_BUSY), 32'd0);
`else
    n = 0;
    repeat (1000) begin
      if (TxD !== 1'b1 || Tx_BUSY !== 1'b0) n++;
      @(negedge clk);
    end
    check("x0F/second_dropped", 32'(n), 32'd0);
`endif

    // Enable dropped during D4 of 0x0C (D4 = 0 on the line)
    send(8'h0C);
    n = 0;
    repeat (5 * BIT_CLKS + 100 - 1) begin
      @(negedge clk);
      if (Tx_DONE === 1'b1) n++;
    end
    check("abort/pre_txd", 32'(TxD), 32'd0);
    check("abort/pre_busy", 32'(Tx_BUSY), 32'd1);
    Tx_EN = 1'b0;
    @(negedge clk);
    check("abort/txd", 32'(TxD), 32'd1);
    check("abort/busy", 32'(Tx_BUSY), 32'd0);
    repeat (20) begin
      if (Tx_DONE === 1'b1) n++;
      @(negedge clk);
    end
    Tx_EN = 1'b1;
    repeat (5000) begin
      if (Tx_DONE === 1'b1 || TxD !== 1'b1) n++;
      @(negedge clk);
    end
    check("abort/no_done", 32'(n), 32'd0);

    // Reset during the parity bit of 0x96 (parity 0 on the line)
    send(8'h96);
    repeat (9 * BIT_CLKS + 200 - 1) @(negedge clk);
    check("rst_mid/pre_txd", 32'(TxD), 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("rst_mid/txd", 32'(TxD), 32'd1);
    check("rst_mid/busy", 32'(Tx_BUSY), 32'd0);
    check("rst_mid/done", 32'(Tx_DONE), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clk);

    send(8'hFF);
    observe_frame("xFF", 8'hFF, -10, 8'h00, par, stp);
    check("xFF/parity", 32'(par), 32'd0);
    check("xFF/stop", 32'(stp), 32'd1);
    @(negedge clk);
    check("xFF/busy_after", 32'(Tx_BUSY), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
